operand_entry_sequencer: RTL
============================

Name: operand_entry_sequencer

Overview:
- Input-side front end of the ALU board: turns one raw, bouncy push-button plus the 8-bit switch operand into a clean, sequenced command stream.
- Sequence per button press: load A, load B, execute, acknowledge.
- Outputs are one-cycle strobes plus a registered data word. They feed the operand registers and operation enable in the ALU datapath, replacing direct use of raw button levels.
- Runs on the divided system clock alongside the seven-segment scanner.

Parameters:
- WIDTH, 8, width of the operand data path.
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required before the debounced level changes; legal range ≥2.
- HOLD_CYCLES, 50000000, debounced-high cycles that count as a long press (used only with the optional feature).

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  1  asynchronous, bouncy push-button level.
- data_in  input  WIDTH  operand switch value.
- data_out  output  WIDTH  operand captured at the last load strobe.
- load_a  output  1  one-cycle strobe: write data_out into A.
- load_b  output  1  one-cycle strobe: write data_out into B.
- exec  output  1  one-cycle strobe: perform the selected operation.
- clr  output  1  one-cycle strobe: clear A, B and Y.
- state  output  2  current FSM state, for LED/debug display.

Behaviour:
- Reset, sampled at a clock edge, sets the following:
  - sync flops, debounced level, delayed debounced level and counter to 0;
  - state = WAIT_A (2'd0);
  - data_out = 0;
  - all strobes low.
- Reset has priority over every other event, including a strobe that would otherwise fire on that edge.
- Synchronizer: btn_raw passes through two flops, s1 then s2. No logic reads s1.
- Debouncer:
  - If s2 equals the debounced level, the counter clears to 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, the debounced level takes s2 and the counter clears.
  - Otherwise the counter increments.
  - Any bounce shorter than DEBOUNCE_CYCLES restarts the count.
- Press detect: press = debounced & ~debounced_d, where debounced_d is debounced delayed by one register. Press is combinational and lasts exactly one cycle. Release produces no action.
- FSM on press; all outputs are registered:
  - WAIT_A (0): load_a=1, data_out<=data_in, next state WAIT_B.
  - WAIT_B (1): load_b=1, data_out<=data_in, next state WAIT_EXEC.
  - WAIT_EXEC (2): exec=1, data_out holds, next state SHOW.
  - SHOW (3): clr=1, data_out<=0, next state WAIT_A.
  - With no press, the state holds and all strobes are 0.
- At most one strobe is high in any cycle. Strobes are never high on two consecutive cycles.
- Latency, with btn_raw held stable:
  - The strobe is high for exactly one cycle, starting after rising edge number DEBOUNCE_CYCLES+3.
  - Edges are counted from 1, where edge 1 is the first edge that samples btn_raw=1.
- data_in changes while no press is pending do not affect data_out.
- Button held through reset: the debounced level restarts at 0, so a held button produces one press after debounce. This press acts on WAIT_A.
- Button held indefinitely: exactly one press. No auto-repeat in the base design.

Optional Feature:
- Macro: OPERAND_SEQ_LONG_PRESS_CLEAR_EN.
- Defined:
  - A hold counter runs while debounced=1, clears when debounced=0, and saturates.
  - When the counter reaches HOLD_CYCLES-1, the block emits clr for one cycle, sets data_out<=0 and forces state to WAIT_A from any state.
  - This fires once per hold. The normal press action has already occurred on the rising edge.
  - If long-press and press occur on the same edge (only possible when HOLD_CYCLES=1), long-press wins.
- Undefined: no hold counter; long presses behave as a single press.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, WIDTH=8):
- Reset then clean press, data_in=8'h3C held: load_a high only in the cycle after edge 7, data_out=8'h3C, state=1; no other strobe.
- Four clean presses with data_in 8'h12 then 8'h34, each held 10 cycles, 10-cycle gaps:
  - strobes in order load_a(12), load_b(34), exec, clr;
  - data_out: 12, 34, 34, 00;
  - state returns to 0.
- Bounce: btn_raw toggles 1,0,1,0 each cycle, then stays high: no strobe during bouncing; one load_a exactly 7 edges after the final rising sample.
- Reset asserted in WAIT_EXEC on the same edge a press would fire: no exec; state=0, data_out=0, all strobes 0.
- Button held 100 cycles, base build: one load_a only, state=1 throughout.
- Button held 100 cycles, macro defined: load_a, then clr 20 cycles after the debounced rise; state=0, data_out=0; no further strobes until release and re-press.

Source files
------------

// File: rtl/operand_entry_sequencer.sv
// Push-button front end for the ALU board: synchronize, debounce, detect a press, then step through
// load A / load B / execute / clear. Optional long-press clear is enabled by OPERAND_SEQ_LONG_PRESS_CLEAR_EN.
module operand_entry_sequencer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             load_a,
    output logic             load_b,
    output logic             exec,
    output logic             clr,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        WAIT_A    = 2'd0,
        WAIT_B    = 2'd1,
        WAIT_EXEC = 2'd2,
        SHOW      = 2'd3
    } state_t;

    localparam int DCW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_bad_params
        $error("operand_entry_sequencer: DEBOUNCE_CYCLES must be >= 2 and HOLD_CYCLES >= 1");
    end

    logic           s1;
    logic           s2;
    logic           debounced;
    logic           debounced_d;
    logic [DCW-1:0] db_cnt;
    logic           press;
    logic           long_press;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            debounced   <= 1'b0;
            debounced_d <= 1'b0;
            db_cnt      <= '0;
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            debounced_d <= debounced;
            if (s2 == debounced) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                debounced <= s2;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + DCW'(1);
            end
        end
    end

    assign press = debounced & ~debounced_d;

`ifdef OPERAND_SEQ_LONG_PRESS_CLEAR_EN
    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_SAT  = HCW'(HOLD_CYCLES);

    logic [HCW-1:0] hold_cnt;

    // Saturating one past the trigger value makes the clear fire exactly once per hold.
    always_ff @(posedge clock) begin
        if (reset || !debounced) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HCW'(1);
        end
    end

    assign long_press = debounced && (hold_cnt == HOLD_LAST);
`else
    assign long_press = 1'b0;
`endif

    state_t           cur_state;
    state_t           next_state;
    logic [WIDTH-1:0] next_data;
    logic             next_load_a;
    logic             next_load_b;
    logic             next_exec;
    logic             next_clr;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        next_state  = cur_state;
        next_data   = data_out;
        next_load_a = 1'b0;
        next_load_b = 1'b0;
        next_exec   = 1'b0;
        next_clr    = 1'b0;
        if (long_press) begin
            next_state = WAIT_A;
            next_data  = '0;
            next_clr   = 1'b1;
        end else if (press) begin
            unique case (cur_state)
                WAIT_A: begin
                    next_load_a = 1'b1;
                    next_data   = data_in;
                    next_state  = WAIT_B;
                end
                WAIT_B: begin
                    next_load_b = 1'b1;
                    next_data   = data_in;
                    next_state  = WAIT_EXEC;
                end
                WAIT_EXEC: begin
                    next_exec  = 1'b1;
                    next_state = SHOW;
                end
                SHOW: begin
                    next_clr   = 1'b1;
                    next_data  = '0;
                    next_state = WAIT_A;
                end
                default: next_state = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= WAIT_A;
            data_out  <= '0;
            load_a    <= 1'b0;
            load_b    <= 1'b0;
            exec      <= 1'b0;
            clr       <= 1'b0;
        end else begin
            cur_state <= next_state;
            data_out  <= next_data;
            load_a    <= next_load_a;
            load_b    <= next_load_b;
            exec      <= next_exec;
            clr       <= next_clr;
        end
    end

    assign state = cur_state;

endmodule
